// File: rtl/led_probe_scanner.sv
// ---------------------------------------------------------------------------
// led_probe_scanner: sweeps SYS_output_sel and streams settled SYS_leds out
// Revision: 1.0
// ---------------------------------------------------------------------------
`default_nettype none

module led_probe_scanner #(
  parameter int NUM_SEL       = 8,
  parameter int SETTLE_CYCLES = 2,
  parameter int SEL_W         = 3,
  parameter int LED_W         = 27
) (
  input  logic             clk,
  input  logic             SYS_reset,
  input  logic             start,
  input  logic             continuous,
  input  logic [LED_W-1:0] SYS_leds,
  output logic [SEL_W-1:0] SYS_output_sel,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [SEL_W-1:0] out_sel,
  output logic [LED_W-1:0] out_data,
  output logic             out_last,
  output logic             busy,
  output logic             done
);

  localparam int               CNT_W    = (SETTLE_CYCLES > 1) ? $clog2(SETTLE_CYCLES) : 1;
  localparam logic [SEL_W-1:0] LAST_SEL = SEL_W'(NUM_SEL - 1);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(SETTLE_CYCLES - 1);

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    SETTLE = 2'd1,
    OFFER  = 2'd2
  } state_t;

  state_t             state, state_n;
  logic [CNT_W-1:0]   cnt, cnt_n;
  logic [SEL_W-1:0]   sel_n, osel_n;
  logic [LED_W-1:0]   data_n;
  logic               valid_n, last_n, busy_n, done_n;

  always_ff @(posedge clk) begin
    if (SYS_reset) begin
      state          <= IDLE;
      cnt            <= '0;
      SYS_output_sel <= '0;
      out_valid      <= 1'b0;
      out_sel        <= '0;
      out_data       <= '0;
      out_last       <= 1'b0;
      busy           <= 1'b0;
      done           <= 1'b0;
    end else begin
      state          <= state_n;
      cnt            <= cnt_n;
      SYS_output_sel <= sel_n;
      out_valid      <= valid_n;
      out_sel        <= osel_n;
      out_data       <= data_n;
      out_last       <= last_n;
      busy           <= busy_n;
      done           <= done_n;
    end
  end

  always_comb begin
    state_n = state;
    cnt_n   = cnt;
    sel_n   = SYS_output_sel;
    valid_n = out_valid;
    osel_n  = out_sel;
    data_n  = out_data;
    last_n  = out_last;
    done_n  = 1'b0;

    case (state)
      IDLE: begin
        if (start) begin
          state_n = SETTLE;
          sel_n   = '0;
          cnt_n   = '0;
        end
      end
      SETTLE: begin
        if (cnt == CNT_LAST) begin
          state_n = OFFER;
          valid_n = 1'b1;
          osel_n  = SYS_output_sel;
          data_n  = SYS_leds;
          last_n  = (SYS_output_sel == LAST_SEL);
        end else begin
          cnt_n = cnt + CNT_W'(1);
        end
      end
      OFFER: begin
        // Record fields stay frozen here; only the handshake moves the sweep on.
        if (out_valid && out_ready) begin
          valid_n = 1'b0;
          cnt_n   = '0;
          if (SYS_output_sel != LAST_SEL) begin
            sel_n   = SYS_output_sel + SEL_W'(1);
            state_n = SETTLE;
          end else begin
            done_n  = 1'b1;
            sel_n   = '0;
            state_n = continuous ? SETTLE : IDLE;
          end
        end
      end
      default: state_n = IDLE;
    endcase

    busy_n = (state_n != IDLE);
  end

endmodule

`default_nettype wire

// File: tb/tb_led_probe_scanner.sv
// ---------------------------------------------------------------------------
// tb_led_probe_scanner: directed stimulus, per-cycle model compare plus literals
// Revision: 1.0
// ---------------------------------------------------------------------------
`default_nettype none

module tb_led_probe_scanner;

  localparam int          NS    = 8;
  localparam int          ST    = 2;
  localparam int          SW    = 3;
  localparam int          LW    = 27;
  localparam logic [LW-1:0] LEDS2 = 27'h2A5A5A5;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic          rst, start, continuous, out_ready;
  logic [LW-1:0] noise;
  logic [SW-1:0] sys_sel, out_sel;
  logic [LW-1:0] out_data;
  logic          out_valid, out_last, busy, done;
  wire  [LW-1:0] leds = LW'(32'(sys_sel) * 32'h111) ^ noise;

  logic          start2, ready2;
  logic [SW-1:0] sys_sel2, out_sel2;
  logic [LW-1:0] out_data2;
  logic          out_valid2, out_last2, busy2, done2;

  led_probe_scanner #(.NUM_SEL(NS), .SETTLE_CYCLES(ST), .SEL_W(SW), .LED_W(LW)) dut (
    .clk(clk), .SYS_reset(rst), .start(start), .continuous(continuous),
    .SYS_leds(leds), .SYS_output_sel(sys_sel), .out_valid(out_valid),
    .out_ready(out_ready), .out_sel(out_sel), .out_data(out_data),
    .out_last(out_last), .busy(busy), .done(done));

  led_probe_scanner #(.NUM_SEL(NS), .SETTLE_CYCLES(4), .SEL_W(SW), .LED_W(LW)) dut_lat (
    .clk(clk), .SYS_reset(rst), .start(start2), .continuous(1'b0),
    .SYS_leds(LEDS2), .SYS_output_sel(sys_sel2), .out_valid(out_valid2),
    .out_ready(ready2), .out_sel(out_sel2), .out_data(out_data2),
    .out_last(out_last2), .busy(busy2), .done(done2));

  int passes = 0;
  int total  = 0;
  bit chk_en = 1'b0;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act === exp) passes++;
    else $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", nm, act, exp, $time);
  endtask

  // Model of the sweep: which select is on the bus, how long it has been held,
  // and the record currently on offer.
  bit            m_active = 0, m_valid = 0, m_last = 0, m_done = 0;
  int            m_sel = 0, m_age = 0, m_osel = 0;
  logic [LW-1:0] m_odata = '0;

  typedef struct {int s; logic [LW-1:0] d; bit l;} rec_t;
  rec_t recs[$];
  int   done_cnt = 0;

  always @(posedge clk) begin
    if (!rst && out_valid && out_ready) begin
      rec_t r;
      r.s = int'(out_sel);
      r.d = out_data;
      r.l = out_last;
      recs.push_back(r);
    end
    if (!rst && done) done_cnt++;

    if (rst) begin
      m_active = 0; m_sel = 0; m_age = 0; m_valid = 0;
      m_osel = 0; m_odata = '0; m_last = 0; m_done = 0;
    end else begin
      m_done = 0;
      if (!m_active) begin
        if (start) begin
          m_active = 1; m_sel = 0; m_age = 0;
        end
      end else if (!m_valid) begin
        m_age++;
        if (m_age == ST) begin
          m_valid = 1;
          m_osel  = m_sel;
          m_odata = LW'(m_sel * 32'h111) ^ noise;
          m_last  = (m_sel == NS - 1);
        end
      end else if (out_ready) begin
        m_valid = 0;
        m_age   = 0;
        if (m_osel < NS - 1) m_sel = m_osel + 1;
        else begin
          m_done   = 1;
          m_sel    = 0;
          m_active = continuous;
        end
      end
    end
  end

  always @(negedge clk) begin
    if (chk_en) begin
      chk("sys_sel",  32'(sys_sel),   32'(m_sel));
      chk("valid",    32'(out_valid), 32'(m_valid));
      chk("out_sel",  32'(out_sel),   32'(m_osel));
      chk("out_data", 32'(out_data),  32'(m_odata));
      chk("out_last", 32'(out_last),  32'(m_last));
      chk("busy",     32'(busy),      32'(m_active));
      chk("done",     32'(done),      32'(m_done));
    end
  end

  task automatic pulse_start();
    @(negedge clk); start = 1'b1;
    @(negedge clk); start = 1'b0;
  endtask

  task automatic wait_done(input int n);
    int g = 0;
    while (done_cnt < n && g < 200) begin @(negedge clk); g++; end
    if (done_cnt < n) chk("timeout_done", 32'(done_cnt), 32'(n));
  endtask

  task automatic wait_vs(input int s);
    int g = 0;
    while (!(out_valid && int'(out_sel) == s) && g < 100) begin @(negedge clk); g++; end
    if (!(out_valid && int'(out_sel) == s)) chk("timeout_sel", 32'(out_sel), 32'(s));
  endtask

  task automatic wait_recs(input int n);
    int g = 0;
    while (recs.size() < n && g < 100) begin @(negedge clk); g++; end
    if (recs.size() < n) chk("timeout_recs", 32'(recs.size()), 32'(n));
  endtask

  task automatic chk_sweep(input string nm);
    chk({nm, "_count"}, 32'(recs.size()), 32'(NS));
    for (int i = 0; i < NS && i < recs.size(); i++) begin
      chk({nm, "_rsel"},  32'(recs[i].s), 32'(i));
      chk({nm, "_rdata"}, 32'(recs[i].d), 32'(i * 32'h111));
      chk({nm, "_rlast"}, 32'(recs[i].l), 32'(i == NS - 1));
    end
  endtask

  initial begin
    int d0;
    rst = 1'b1; start = 1'b1; continuous = 1'b0; out_ready = 1'b1; noise = '0;
    start2 = 1'b0; ready2 = 1'b0;
    repeat (2) @(negedge clk);
    chk_en = 1'b1;
    chk("rst_busy",  32'(busy),      32'd0);
    chk("rst_valid", 32'(out_valid), 32'd0);
    chk("rst_sel",   32'(sys_sel),   32'd0);
    chk("rst_data",  32'(out_data),  32'd0);
    chk("rst_done",  32'(done),      32'd0);
    rst = 1'b0; start = 1'b0;

    // Latency with four settle cycles: start sampled at E0, valid after E4 only.
    start2 = 1'b1;
    @(negedge clk); start2 = 1'b0;
    for (int k = 1; k <= 4; k++) begin
      @(negedge clk);
      chk("lat_valid", 32'(out_valid2), 32'(k == 4));
    end
    chk("lat_data", 32'(out_data2), 32'(LEDS2));
    chk("lat_sel",  32'(out_sel2),  32'd0);

    // Single sweep.
    recs.delete(); d0 = done_cnt;
    pulse_start();
    wait_done(d0 + 1);
    @(negedge clk);
    chk_sweep("sweep");
    chk("sweep_idle", 32'(busy), 32'd0);
    chk("sweep_done_pulses", 32'(done_cnt), 32'(d0 + 1));

    // Backpressure on sel 3 while the LED input toggles.
    recs.delete(); d0 = done_cnt;
    pulse_start();
    wait_vs(3);
    out_ready = 1'b0;
    for (int k = 0; k < 5; k++) begin
      noise = ~noise;
      @(negedge clk);
      chk("bp_osel", 32'(out_sel),   32'd3);
      chk("bp_ssel", 32'(sys_sel),   32'd3);
      chk("bp_data", 32'(out_data),  32'h333);
      chk("bp_vld",  32'(out_valid), 32'd1);
    end
    out_ready = 1'b1; noise = '0;
    wait_done(d0 + 1);
    @(negedge clk);
    chk_sweep("bp");

    // Continuous mode, dropped mid-way through the second sweep.
    recs.delete(); d0 = done_cnt;
    continuous = 1'b1;
    pulse_start();
    wait_done(d0 + 1);
    wait_recs(10);
    if (recs.size() >= 10) chk("cont_restart_sel", 32'(recs[8].s), 32'd0);
    chk("cont_busy", 32'(busy), 32'd1);
    continuous = 1'b0;
    wait_done(d0 + 2);
    repeat (2) @(negedge clk);
    chk("cont_idle",  32'(busy),        32'd0);
    chk("cont_count", 32'(recs.size()), 32'(2 * NS));

    // Reset while offering sel 5.
    pulse_start();
    wait_vs(5);
    out_ready = 1'b0;
    @(negedge clk); rst = 1'b1;
    @(negedge clk);
    chk("mrst_valid", 32'(out_valid), 32'd0);
    chk("mrst_busy",  32'(busy),      32'd0);
    chk("mrst_sel",   32'(sys_sel),   32'd0);
    chk("mrst_osel",  32'(out_sel),   32'd0);
    rst = 1'b0; out_ready = 1'b1;

    // start held high during a sweep must not disturb it.
    @(negedge clk);
    recs.delete(); d0 = done_cnt;
    start = 1'b1;
    repeat (12) @(negedge clk);
    start = 1'b0;
    wait_done(d0 + 1);
    @(negedge clk);
    chk_sweep("hold_start");

    repeat (2) @(negedge clk);
    $display("%0d/%0d checks passed", passes, total);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish, %0d/%0d so far", passes, total);
    $fatal(1);
  end

endmodule

`default_nettype wire
